// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with a registered issue stage feeding the ALU and a registered response stage.
package multicore_pkg;
  localparam int DATA_SIZE = 32;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    SRL  = 4'd5,
    SRA  = 4'd6,
    LXOR = 4'd7,
    LOR  = 4'd8,
    LAND = 4'd9
  } t_aluop;
endpackage

module alu
  import multicore_pkg::*;
(
  input  t_aluop                       funct,
  input  logic signed [DATA_SIZE-1:0]  op_a,
  input  logic signed [DATA_SIZE-1:0]  op_b,
  output logic signed [DATA_SIZE-1:0]  result
);
  // Shift amounts use the full op_b value; large shifts saturate naturally.
  always_comb begin
    result = {DATA_SIZE{1'b0}};
    case (funct)
      ADD:     result = op_a + op_b;
      SUB:     result = op_a - op_b;
      SLL:     result = op_a << op_b;
      SLT:     result = {{(DATA_SIZE-1){1'b0}}, (op_a < op_b)};
      SLTU:    result = {{(DATA_SIZE-1){1'b0}}, ($unsigned(op_a) < $unsigned(op_b))};
      SRL:     result = $unsigned(op_a) >> op_b;
      SRA:     result = op_a >>> op_b;
      LXOR:    result = op_a ^ op_b;
      LOR:     result = op_a | op_b;
      LAND:    result = op_a & op_b;
      default: result = {DATA_SIZE{1'bx}};
    endcase
  end
endmodule

module alu_share_arbiter
  import multicore_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic        [NUM_REQ-1:0]                  i_req_valid,
  input  t_aluop      [NUM_REQ-1:0]                  i_req_funct,
  input  logic signed [NUM_REQ-1:0][DATA_SIZE-1:0]   i_req_op_a,
  input  logic signed [NUM_REQ-1:0][DATA_SIZE-1:0]   i_req_op_b,
  output logic        [NUM_REQ-1:0]                  o_req_ready,
  output logic        [NUM_REQ-1:0]                  o_rsp_valid,
  output logic        [ID_W-1:0]                     o_rsp_id,
  output logic signed [DATA_SIZE-1:0]                o_rsp_result,
  output logic                                       o_busy
);
  logic        [ID_W-1:0]      rr_ptr;
  logic        [NUM_REQ-1:0]   grant;
  logic        [ID_W-1:0]      gnt_id;
  logic        [ID_W:0]        scan_sum;
  logic        [ID_W-1:0]      scan_idx;
  logic                        found;
  logic                        cand;
  logic                        hs;
  logic        [ID_W-1:0]      ptr_next;
  logic                        iss_valid;
  t_aluop                      iss_funct;
  logic signed [DATA_SIZE-1:0] iss_op_a;
  logic signed [DATA_SIZE-1:0] iss_op_b;
  logic        [ID_W-1:0]      iss_id;
  logic signed [DATA_SIZE-1:0] alu_result;

  // Round-robin scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant    = {NUM_REQ{1'b0}};
    gnt_id   = {ID_W{1'b0}};
    found    = 1'b0;
    scan_sum = {(ID_W+1){1'b0}};
    scan_idx = {ID_W{1'b0}};
    cand     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      scan_idx = (scan_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(scan_sum - (ID_W+1)'(NUM_REQ))
                                                   : ID_W'(scan_sum);
      cand     = !found && i_req_valid[scan_idx];
      grant[scan_idx] = grant[scan_idx] | cand;
      gnt_id   = cand ? scan_idx : gnt_id;
      found    = found | cand;
    end
  end

  assign o_req_ready = i_reset ? {NUM_REQ{1'b0}} : grant;
  assign hs          = |o_req_ready;
  assign ptr_next    = (gnt_id == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : gnt_id + ID_W'(1);

  alu u_alu (
    .funct  (iss_funct),
    .op_a   (iss_op_a),
    .op_b   (iss_op_b),
    .result (alu_result)
  );

  // Pointer, issue stage and response stage; o_busy tracks the next-cycle occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr       <= {ID_W{1'b0}};
      iss_valid    <= 1'b0;
      iss_funct    <= ADD;
      iss_op_a     <= {DATA_SIZE{1'b0}};
      iss_op_b     <= {DATA_SIZE{1'b0}};
      iss_id       <= {ID_W{1'b0}};
      o_rsp_valid  <= {NUM_REQ{1'b0}};
      o_rsp_id     <= {ID_W{1'b0}};
      o_rsp_result <= {DATA_SIZE{1'b0}};
      o_busy       <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr    <= ptr_next;
        iss_valid <= 1'b1;
        iss_funct <= i_req_funct[gnt_id];
        iss_op_a  <= i_req_op_a[gnt_id];
        iss_op_b  <= i_req_op_b[gnt_id];
        iss_id    <= gnt_id;
      end else begin
        iss_valid <= 1'b0;
      end
      if (iss_valid) begin
        o_rsp_valid  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << iss_id;
        o_rsp_id     <= iss_id;
        o_rsp_result <= alu_result;
      end else begin
        o_rsp_valid  <= {NUM_REQ{1'b0}};
      end
      o_busy <= hs | iss_valid;
    end
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance among NUM_REQ requesters, e.g. the cores in the multicore cluster.
- Grants at most one request per cycle using round-robin priority.
- Registers the granted operation into an issue stage that drives the `alu`, then registers the result into a response stage with the requester ID.
- Sits between the per-core execute stages and a single `alu` instance, which the block instantiates internally.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, $clog2(NUM_REQ): width of the requester ID.
- DATA_SIZE, from multicore_pkg: operand and result width. Not overridable.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- i_req_funct  input  NUM_REQ x t_aluop  per-requester operation, packed array.
- i_req_op_a  input  NUM_REQ x DATA_SIZE  per-requester operand A, signed.
- i_req_op_b  input  NUM_REQ x DATA_SIZE  per-requester operand B, signed.
- o_req_ready  output  NUM_REQ  one-hot grant, combinational.
- o_rsp_valid  output  NUM_REQ  one-hot response strobe, registered.
- o_rsp_id  output  ID_W  ID of the requester being answered.
- o_rsp_result  output  DATA_SIZE  ALU result, signed.
- o_busy  output  1  high while the issue or response stage holds an operation.

Behaviour:
- Reset: applies to all state and outputs. Synchronous, active-high, dominates all other events.
  - rr_ptr=0.
  - Issue stage: iss_valid=0, iss_funct=ADD, operands 0.
  - Response stage: o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0.
  - o_busy=0.
  - o_req_ready=0 while i_reset=1.
- Grant (combinational):
  - Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first with i_req_valid=1 receives o_req_ready=1; all others get 0.
  - No valid requests gives o_req_ready=0.
  - A handshake occurs when valid and ready are both high for the same requester.
- Requester rules:
  - A requester must hold valid, funct and operands stable until granted.
  - A requester may drop valid only after its handshake.
- Pointer update: on a handshake with requester g, rr_ptr <= (g+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Issue stage: on a handshake, load iss_funct, iss_op_a, iss_op_b and iss_id=g, and set iss_valid=1. Otherwise iss_valid <= 0.
- ALU: combinational, fed from the issue registers.
- Response stage, every cycle:
  - o_rsp_result <= alu result.
  - o_rsp_id <= iss_id.
  - o_rsp_valid <= iss_valid ? (1<<iss_id) : 0.
  - o_rsp_result and o_rsp_id hold their previous value when iss_valid=0.
- Latency and throughput:
  - Handshake in cycle N gives o_rsp_valid in cycle N+2.
  - Throughput is 1 op/cycle.
  - Responses have no backpressure; requesters must accept the strobe.
- o_busy = iss_valid | (|o_rsp_valid).
- Arithmetic rules:
  - Width and semantics follow the ALU exactly.
  - Shifts use the full op_b value, with no masking added here.
  - SLT/SLTU results are zero-extended 0/1.
  - An undefined funct yields X. The bench must never drive one.
- Simultaneous events:
  - A new handshake in the same cycle as the issue-to-response transfer is normal pipelining; no bubble is inserted.
- Fairness: a continuously requesting requester is granted within NUM_REQ cycles.
- Reset mid-operation: in-flight issue and response contents are discarded, and no o_rsp_valid is produced afterwards for them.

Test Plan:
- Single requester: NUM_REQ=4, req1 ADD 5+7 in cycle 0 → o_req_ready=0010 in cycle 0; o_rsp_valid=0010, id=1, result=12 in cycle 2.
- All four requesters hold valid, rr_ptr=0, each issuing SUB 10-k:
  - Grants are 0,1,2,3,0 on consecutive cycles.
  - Responses appear in the same order 2 cycles later: 10,9,8,7.
- Wrap-around: rr_ptr=3 after granting req2; req0 and req3 valid → req3 granted first, then req0.
- Signed ops: SRA 0x80000000>>>4 → 0xF8000000. SLTU -1 vs 1 → 0. SLT -1 vs 1 → 1.
- Back-to-back, then idle: req2 grants in cycles 0 and 1, then valid drops:
  - o_rsp_valid is high in cycles 2 and 3, low in cycle 4.
  - o_busy is high in cycles 1-3 and low from cycle 4.
- Reset mid-flight: i_reset in cycle 1 after a cycle-0 handshake → no o_rsp_valid in cycle 2; rr_ptr=0; all outputs 0.
